// File: rtl/fifo_wt_arb.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ requesters.
// Packets are never interleaved, and writes are throttled against w_emptycount.
module fifo_wt_arb #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int ID_W  = $clog2(N_REQ),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     a_rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_last,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [CNT_W-1:0]         w_emptycount,
    output logic                     wt,
    output logic [WIDTH-1:0]         wtdata,
    output logic [ID_W-1:0]          grant_id,
    output logic                     locked,
    output logic [15:0]              words_written
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  lock_id;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  cand;
    logic [ID_W-1:0]  rr_nxt;
    logic             win_found;
    logic             space;
    logic             accept;
    logic             acc_last;
    logic [WIDTH-1:0] acc_data;

    // A write still in flight is not yet counted by w_emptycount, so reserve a slot for it.
    assign space = (w_emptycount > {{(CNT_W-1){1'b0}}, wt});

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        if (state == ST_LOCKED) begin
            win_found = req_valid[lock_id];
            win_id    = lock_id;
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                cand = ID_W'((32'(rr_ptr) + k) % N_REQ);
                if (!win_found && req_valid[cand]) begin
                    win_found = 1'b1;
                    win_id    = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (win_found && space) begin
            req_ready[win_id] = 1'b1;
        end
    end

    assign accept = win_found & space;

    always_comb begin
        acc_last = 1'b0;
        acc_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == win_id) begin
                acc_last = req_last[i];
                acc_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign rr_nxt = (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + 1'b1;

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = acc_last ? ST_IDLE : ST_LOCKED;
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            lock_id       <= '0;
            wt            <= 1'b0;
            wtdata        <= '0;
            grant_id      <= '0;
            locked        <= 1'b0;
            words_written <= '0;
        end else begin
            state  <= state_nxt;
            locked <= (state_nxt == ST_LOCKED);
            wt     <= accept;
            wtdata <= accept ? acc_data : '0;
            if (accept) begin
                grant_id      <= win_id;
                words_written <= words_written + 16'd1;
                if (acc_last) begin
                    rr_ptr <= rr_nxt;
                end else begin
                    lock_id <= win_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_wt_arb.sv
// Randomized and directed bench for fifo_wt_arb against a packet-level arbiter model
// driving w_emptycount from a simple occupancy model of the downstream FIFO.
module tb_fifo_wt_arb;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int D  = 16;
    localparam int CW = 5;

    logic            clk = 1'b0;
    logic            a_rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_ready;
    logic [CW-1:0]   w_emptycount;
    logic            wt;
    logic [W-1:0]    wtdata;
    logic [1:0]      grant_id;
    logic            locked;
    logic [15:0]     words_written;

    fifo_wt_arb #(.N_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
        .clk           (clk),
        .a_rst_n       (a_rst_n),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .w_emptycount  (w_emptycount),
        .wt            (wt),
        .wtdata        (wtdata),
        .grant_id      (grant_id),
        .locked        (locked),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference state: packet ownership, rotation start, registered outputs
    bit m_lock;
    int m_owner;
    int m_rr;
    int m_wt;
    int m_wtdata;
    int m_gid;
    int m_words;
    // downstream FIFO occupancy model
    int occ;
    int cap;
    bit rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_owner = 0; m_rr = 0;
        m_wt = 0; m_wtdata = 0; m_gid = 0; m_words = 0;
    endtask

    task automatic set_req(input int i, input bit v, input bit l, input int d);
        req_valid[i] = v;
        req_last[i]  = l;
        req_data[i*W +: W] = W'(d);
    endtask

    // one clock: check combinational ready, advance, check registered outputs
    task automatic step();
        int  win;
        bit  sp;
        bit  rd_ok;
        logic [N-1:0] exp_ready;
        w_emptycount = CW'(cap - occ);
        #1;
        sp  = (cap - occ) > m_wt;
        win = -1;
        if (m_lock) begin
            if (req_valid[m_owner]) win = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && req_valid[(m_rr + k) % N]) win = (m_rr + k) % N;
            end
        end
        exp_ready = '0;
        if (sp && win >= 0) exp_ready[win] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
        rd_ok = rd && (occ > 0);
        occ = occ + m_wt - int'(rd_ok);
        chk("no_overrun", 32'(occ <= cap), 32'd1);
        if (sp && win >= 0) begin
            m_wt     = 1;
            m_wtdata = int'(req_data[win*W +: W]);
            m_gid    = win;
            m_words++;
            if (req_last[win]) begin
                m_lock = 0;
                m_rr   = (win + 1) % N;
            end else begin
                m_lock  = 1;
                m_owner = win;
            end
        end else begin
            m_wt = 0;
            m_wtdata = 0;
        end
        chk("wt", 32'(wt), 32'(m_wt));
        chk("wtdata", 32'(wtdata), 32'(m_wtdata));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("locked", 32'(locked), 32'(m_lock));
        chk("words_written", 32'(words_written), 32'(m_words % 65536));
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_wt"}, 32'(wt), 32'd0);
        chk({tag, "_wtdata"}, 32'(wtdata), 32'd0);
        chk({tag, "_grant"}, 32'(grant_id), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_words"}, 32'(words_written), 32'd0);
    endtask

    int nwr;

    initial begin
        a_rst_n = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0;
        occ = 0; cap = D; rd = 1'b0;
        w_emptycount = CW'(D);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_outs_zero("reset");
        a_rst_n = 1'b1;

        // reset priority: everyone valid with single-word packets
        rd = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 8'h10 + i);
        for (int j = 0; j < 8; j++) begin
            step();
            chk("prio_seq", 32'(wtdata), 32'h10 + 32'(j % 4));
            chk("prio_wt", 32'(wt), 32'd1);
        end

        // packet lock: req0 sends A0,A1,A2 while req1 waits
        req_valid = '0;
        set_req(1, 1'b1, 1'b1, 8'hB1);
        set_req(0, 1'b1, 1'b0, 8'hA0); step();
        chk("pkt_a0", 32'(wtdata), 32'hA0); chk("pkt_lock0", 32'(locked), 32'd1);
        set_req(0, 1'b1, 1'b0, 8'hA1); step();
        chk("pkt_a1", 32'(wtdata), 32'hA1); chk("pkt_lock1", 32'(locked), 32'd1);
        set_req(0, 1'b1, 1'b1, 8'hA2); step();
        chk("pkt_a2", 32'(wtdata), 32'hA2); chk("pkt_lock2", 32'(locked), 32'd0);
        set_req(0, 1'b0, 1'b0, 8'h00); step();
        chk("pkt_b1", 32'(wtdata), 32'hB1); chk("pkt_lock3", 32'(locked), 32'd0);

        // lock stall: req2 opens a packet then goes quiet while req3 waits
        req_valid = '0;
        step();
        set_req(2, 1'b1, 1'b0, 8'hC0); step();
        chk("stall_open", 32'(locked), 32'd1);
        set_req(2, 1'b0, 1'b0, 8'h00);
        set_req(3, 1'b1, 1'b1, 8'hD3);
        for (int j = 0; j < 5; j++) begin
            step();
            chk("stall_ready3", 32'(req_ready[3]), 32'd0);
            chk("stall_wt", 32'(wt), 32'd0);
        end
        set_req(2, 1'b1, 1'b1, 8'hC1); step();
        chk("stall_resume", 32'(wtdata), 32'hC1);
        set_req(2, 1'b0, 1'b0, 8'h00); step();
        chk("stall_then3", 32'(wtdata), 32'hD3);

        // full throttle against a 4-deep FIFO with no reads
        req_valid = '0; rd = 1'b0;
        step();
        occ = 0; cap = 4;
        set_req(1, 1'b1, 1'b1, 8'h55);
        nwr = 0;
        for (int j = 0; j < 12; j++) begin
            step();
            if (wt) nwr++;
        end
        chk("full_writes", 32'(nwr), 32'd4);
        chk("full_ready", 32'(req_ready), 32'd0);
        rd = 1'b1; step(); rd = 1'b0;
        nwr = int'(wt);
        for (int j = 0; j < 8; j++) begin
            step();
            if (wt) nwr++;
        end
        chk("full_one_more", 32'(nwr), 32'd1);

        // randomized traffic with random reads
        req_valid = '0;
        step();
        cap = D;
        for (int j = 0; j < 600; j++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'(($urandom % 4) != 0), 1'(($urandom % 3) == 0), int'($urandom % 256));
            rd = 1'($urandom % 2);
            step();
        end

        // async reset mid-packet
        rd = 1'b1;
        req_valid = '0;
        set_req(1, 1'b1, 1'b1, 8'h11); step();
        set_req(1, 1'b1, 1'b0, 8'h21); step();
        set_req(1, 1'b1, 1'b0, 8'h22); step();
        chk("arst_pre_locked", 32'(locked), 32'd1);
        #1 a_rst_n = 1'b0;
        #1 chk_outs_zero("arst");
        model_reset();
        #4 a_rst_n = 1'b1;
        set_req(0, 1'b1, 1'b1, 8'h30);
        set_req(1, 1'b1, 1'b1, 8'h31);
        step();
        chk("arst_req0_wins", 32'(wtdata), 32'h30);

        // counter wrap
        req_valid = '0;
        a_rst_n = 1'b0;
        @(posedge clk); #1;
        a_rst_n = 1'b1;
        model_reset();
        set_req(0, 1'b1, 1'b1, 8'h77);
        rd = 1'b1;
        for (int j = 0; j < 65537; j++) step();
        chk("wrap_words", 32'(words_written), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
